sram_arbiter: RTL and testbench

Shares the single SRAM controller between two read clients (display scan-out and game logic) and two write clients (game logic and maze generator). The block runs a 4-cycle slot phase counter matched to the controller's read/idle/write/idle cycle. It grants at most one read and one write per slot and drives the controller's `rd_addr`, `wr_en`, `wr_addr` and `wr_data` inputs. It returns captured read data to the granted client with a one-cycle valid pulse.

---
 rtl/sram_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller between two read clients and two
// write clients using a 4-cycle slot (p0 read addr, p1 idle, p2 write, p3 idle).
// At most one read and one write are granted per slot; read data is returned
// to its owner with a one-cycle valid pulse one slot after the grant.
// Build option: define SRAM_ARB_WR_RR_EN for round-robin write arbitration;
// otherwise writes use fixed priority (wr0 over wr1).
module sram_arbiter #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_100m,
  input  logic              rst_n,
  input  logic              rd0_req,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic              rd0_ack,
  output logic              rd0_valid,
  output logic [DATA_W-1:0] rd0_data,
  input  logic              rd1_req,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd1_ack,
  output logic              rd1_valid,
  output logic [DATA_W-1:0] rd1_data,
  input  logic              wr0_req,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  output logic              wr0_ack,
  input  logic              wr1_req,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic              wr1_ack,
  output logic [ADDR_W-1:0] ctl_rd_addr,
  input  logic [DATA_W-1:0] ctl_rd_data,
  output logic              ctl_wr_en,
  output logic [ADDR_W-1:0] ctl_wr_addr,
  output logic [DATA_W-1:0] ctl_wr_data,
  output logic [1:0]        phase
);

  localparam int unsigned PH_W = 2;

  typedef enum logic [PH_W-1:0] {
    PH_RD      = 2'd0,
    PH_RD_WAIT = 2'd1,
    PH_WR      = 2'd2,
    PH_WR_WAIT = 2'd3
  } phase_t;

  phase_t state_q;
  phase_t state_d;
  logic   rd_decide_c;
  logic   wr_decide_c;
  logic   wr0_gnt_c;
  logic   wr1_gnt_c;
  logic   rd_busy_q;
  logic   rd_owner_q;

  // Slot phase register
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PH_RD;
    end else begin
      state_q <= state_d;
    end
  end

  // Phase sequencing and decision-edge strobes
  always_comb begin
    state_d     = state_q;
    rd_decide_c = 1'b0;
    wr_decide_c = 1'b0;
    case (state_q)
      PH_RD:      state_d = PH_RD_WAIT;
      PH_RD_WAIT: begin
        state_d     = PH_WR;
        wr_decide_c = 1'b1;
      end
      PH_WR:      state_d = PH_WR_WAIT;
      PH_WR_WAIT: begin
        state_d     = PH_RD;
        rd_decide_c = 1'b1;
      end
      default:    state_d = PH_RD;
    endcase
  end

  assign phase = state_q;

`ifdef SRAM_ARB_WR_RR_EN
  logic wr_ptr_q;

  // Round-robin write select: pointer breaks ties, lone requester always wins
  always_comb begin
    wr0_gnt_c = 1'b0;
    wr1_gnt_c = 1'b0;
    if (wr0_req && wr1_req) begin
      wr1_gnt_c = wr_ptr_q;
      wr0_gnt_c = !wr_ptr_q;
    end else begin
      wr0_gnt_c = wr0_req;
      wr1_gnt_c = wr1_req;
    end
  end

  // Pointer moves to the writer that did not win
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
    end else if (wr_decide_c) begin
      if (wr0_gnt_c) begin
        wr_ptr_q <= 1'b1;
      end else if (wr1_gnt_c) begin
        wr_ptr_q <= 1'b0;
      end
    end
  end
`else
  // Fixed-priority write select: wr0 over wr1
  always_comb begin
    wr0_gnt_c = wr0_req;
    wr1_gnt_c = wr1_req && !wr0_req;
  end
`endif

  // Read return of the previous slot and new read grant, both at the end of p3
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      rd0_ack     <= 1'b0;
      rd1_ack     <= 1'b0;
      rd0_valid   <= 1'b0;
      rd1_valid   <= 1'b0;
      rd0_data    <= '0;
      rd1_data    <= '0;
      ctl_rd_addr <= '0;
      rd_busy_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
    end else begin
      rd0_ack   <= 1'b0;
      rd1_ack   <= 1'b0;
      rd0_valid <= 1'b0;
      rd1_valid <= 1'b0;
      if (rd_decide_c) begin
        if (rd_busy_q) begin
          if (rd_owner_q) begin
            rd1_data  <= ctl_rd_data;
            rd1_valid <= 1'b1;
          end else begin
            rd0_data  <= ctl_rd_data;
            rd0_valid <= 1'b1;
          end
        end
        if (rd0_req) begin
          ctl_rd_addr <= rd0_addr;
          rd0_ack     <= 1'b1;
          rd_owner_q  <= 1'b0;
          rd_busy_q   <= 1'b1;
        end else if (rd1_req) begin
          ctl_rd_addr <= rd1_addr;
          rd1_ack     <= 1'b1;
          rd_owner_q  <= 1'b1;
          rd_busy_q   <= 1'b1;
        end else begin
          rd_busy_q   <= 1'b0;
        end
      end
    end
  end

  // Write grant at the end of p1; write enable spans p2..p3
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      wr0_ack     <= 1'b0;
      wr1_ack     <= 1'b0;
      ctl_wr_en   <= 1'b0;
      ctl_wr_addr <= '0;
      ctl_wr_data <= '0;
    end else begin
      wr0_ack <= 1'b0;
      wr1_ack <= 1'b0;
      if (rd_decide_c) begin
        ctl_wr_en <= 1'b0;
      end
      if (wr_decide_c) begin
        if (wr0_gnt_c) begin
          ctl_wr_addr <= wr0_addr;
          ctl_wr_data <= wr0_data;
          ctl_wr_en   <= 1'b1;
          wr0_ack     <= 1'b1;
        end else if (wr1_gnt_c) begin
          ctl_wr_addr <= wr1_addr;
          ctl_wr_data <= wr1_data;
          ctl_wr_en   <= 1'b1;
          wr1_ack     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: slot-level reference model of the arbiter driving the DUT
// against a simple SRAM controller model (read at p0, write at p2).
module tb_sram_arbiter;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MEM_N  = 64;

  logic              clk_100m = 1'b0;
  logic              rst_n    = 1'b0;
  logic              rd0_req, rd1_req, wr0_req, wr1_req;
  logic [ADDR_W-1:0] rd0_addr, rd1_addr, wr0_addr, wr1_addr;
  logic [DATA_W-1:0] wr0_data, wr1_data;
  logic              rd0_ack, rd0_valid, rd1_ack, rd1_valid, wr0_ack, wr1_ack;
  logic [DATA_W-1:0] rd0_data, rd1_data;
  logic [ADDR_W-1:0] ctl_rd_addr, ctl_wr_addr;
  logic [DATA_W-1:0] ctl_rd_data = '0;
  logic [DATA_W-1:0] ctl_wr_data;
  logic              ctl_wr_en;
  logic [1:0]        phase;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_100m = ~clk_100m;

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_100m(clk_100m), .rst_n(rst_n),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_ack(rd0_ack),
    .rd0_valid(rd0_valid), .rd0_data(rd0_data),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_ack(rd1_ack),
    .rd1_valid(rd1_valid), .rd1_data(rd1_data),
    .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ack(wr0_ack),
    .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ack(wr1_ack),
    .ctl_rd_addr(ctl_rd_addr), .ctl_rd_data(ctl_rd_data),
    .ctl_wr_en(ctl_wr_en), .ctl_wr_addr(ctl_wr_addr), .ctl_wr_data(ctl_wr_data),
    .phase(phase)
  );

  function automatic logic [DATA_W-1:0] init_val(input int i);
    return 32'hA5A50000 | DATA_W'(i);
  endfunction

  // SRAM controller model: own slot counter, read address sampled in p0, write in p2
  logic [DATA_W-1:0] sram [MEM_N];
  logic [1:0]        env_p;
  bit                mem_loaded = 1'b0;
  always @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      env_p <= 2'd0;
      if (!mem_loaded) begin
        for (int i = 0; i < MEM_N; i++) sram[i] <= init_val(i);
        mem_loaded <= 1'b1;
      end
    end else begin
      env_p <= env_p + 2'd1;
      if (env_p == 2'd0) ctl_rd_data <= sram[ctl_rd_addr[5:0]];
      if (env_p == 2'd2 && ctl_wr_en) sram[ctl_wr_addr[5:0]] <= ctl_wr_data;
    end
  end

  // Reference model state (per slot)
  bit                r_pend [2];
  bit                r_sticky [2];
  logic [ADDR_W-1:0] r_addr [2];
  bit                w_pend [2];
  bit                w_sticky [2];
  logic [ADDR_W-1:0] w_addr [2];
  logic [DATA_W-1:0] w_data [2];
  logic [DATA_W-1:0] ref_mem [MEM_N];
  logic [DATA_W-1:0] exp_rd_data [2];
  int                rd_gnt;
  logic [ADDR_W-1:0] rd_gnt_addr;
  int                rd_ret;
  logic [DATA_W-1:0] rd_ret_data;
  bit                wr_ptr;
  bit                rand_mode;
  int                rand_pct;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    rd0_req  = r_pend[0]; rd0_addr = r_addr[0];
    rd1_req  = r_pend[1]; rd1_addr = r_addr[1];
    wr0_req  = w_pend[0]; wr0_addr = w_addr[0]; wr0_data = w_data[0];
    wr1_req  = w_pend[1]; wr1_addr = w_addr[1]; wr1_data = w_data[1];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      r_pend[i] = 1'b0; r_sticky[i] = 1'b0; r_addr[i] = '0;
      w_pend[i] = 1'b0; w_sticky[i] = 1'b0; w_addr[i] = '0; w_data[i] = '0;
      exp_rd_data[i] = '0;
    end
    rd_gnt = -1; rd_gnt_addr = '0; rd_ret = -1; rd_ret_data = '0; wr_ptr = 1'b0;
  endtask

  // One slot, entered and left at the negedge inside p0
  task automatic run_slot();
    int                wg;
    int                nret;
    logic [DATA_W-1:0] nret_data;
    drive();
    check("phase_p0", 64'(phase), 64'd0);
    check("rd0_ack", 64'(rd0_ack), 64'(rd_gnt == 0));
    check("rd1_ack", 64'(rd1_ack), 64'(rd_gnt == 1));
    if (rd_gnt >= 0) check("ctl_rd_addr", 64'(ctl_rd_addr), 64'(rd_gnt_addr));
    check("rd0_valid", 64'(rd0_valid), 64'(rd_ret == 0));
    check("rd1_valid", 64'(rd1_valid), 64'(rd_ret == 1));
    if (rd_ret >= 0) exp_rd_data[rd_ret] = rd_ret_data;
    check("rd0_data", 64'(rd0_data), 64'(exp_rd_data[0]));
    check("rd1_data", 64'(rd1_data), 64'(exp_rd_data[1]));
    check("wr_en_p0", 64'(ctl_wr_en), 64'd0);
    check("wr_ack_p0", 64'({wr1_ack, wr0_ack}), 64'd0);
    // Read in this slot sees memory before this slot's write
    nret = rd_gnt;
    nret_data = (rd_gnt >= 0) ? ref_mem[rd_gnt_addr[5:0]] : '0;
    if (rd_gnt >= 0) r_pend[rd_gnt] = r_sticky[rd_gnt];
    if (rand_mode) begin
      for (int i = 0; i < 2; i++) begin
        if (!r_pend[i] && $urandom_range(99) < rand_pct) begin
          r_pend[i] = 1'b1;
          r_addr[i] = ADDR_W'($urandom_range(MEM_N - 1));
        end
      end
    end
    drive();
    @(negedge clk_100m);
    check("phase_p1", 64'(phase), 64'd1);
    check("acks_p1", 64'({rd1_ack, rd0_ack, wr1_ack, wr0_ack}), 64'd0);
    check("valid_p1", 64'({rd1_valid, rd0_valid}), 64'd0);
    check("wr_en_p1", 64'(ctl_wr_en), 64'd0);
    wg = -1;
    if (w_pend[0] && w_pend[1]) begin
`ifdef SRAM_ARB_WR_RR_EN
      wg = wr_ptr ? 1 : 0;
`else
      wg = 0;
`endif
    end else if (w_pend[0]) begin
      wg = 0;
    end else if (w_pend[1]) begin
      wg = 1;
    end
    if (wg >= 0) wr_ptr = (wg == 0);
    @(negedge clk_100m);
    check("phase_p2", 64'(phase), 64'd2);
    check("wr0_ack", 64'(wr0_ack), 64'(wg == 0));
    check("wr1_ack", 64'(wr1_ack), 64'(wg == 1));
    check("wr_en_p2", 64'(ctl_wr_en), 64'(wg >= 0));
    check("rd_acks_p2", 64'({rd1_ack, rd0_ack}), 64'd0);
    if (wg >= 0) begin
      check("ctl_wr_addr", 64'(ctl_wr_addr), 64'(w_addr[wg]));
      check("ctl_wr_data", 64'(ctl_wr_data), 64'(w_data[wg]));
      ref_mem[w_addr[wg][5:0]] = w_data[wg];
      w_pend[wg] = w_sticky[wg];
      if (w_sticky[wg]) w_data[wg] = $urandom;
    end
    if (rand_mode) begin
      for (int i = 0; i < 2; i++) begin
        if (!w_pend[i] && $urandom_range(99) < rand_pct) begin
          w_pend[i] = 1'b1;
          w_addr[i] = ADDR_W'($urandom_range(MEM_N - 1));
          w_data[i] = $urandom;
        end
      end
    end
    drive();
    @(negedge clk_100m);
    check("phase_p3", 64'(phase), 64'd3);
    check("wr_en_p3", 64'(ctl_wr_en), 64'(wg >= 0));
    check("acks_p3", 64'({rd1_ack, rd0_ack, wr1_ack, wr0_ack}), 64'd0);
    // Read grant: rd0 first, then rd1
    rd_gnt = r_pend[0] ? 0 : (r_pend[1] ? 1 : -1);
    if (rd_gnt >= 0) rd_gnt_addr = r_addr[rd_gnt];
    rd_ret = nret;
    rd_ret_data = nret_data;
    @(negedge clk_100m);
  endtask

  initial begin
    model_reset();
    rand_mode = 1'b0;
    rand_pct  = 50;
    for (int i = 0; i < MEM_N; i++) ref_mem[i] = init_val(i);
    drive();
    repeat (2) @(negedge clk_100m);

    // Reset values
    check("rst_phase", 64'(phase), 64'd0);
    check("rst_acks", 64'({rd1_ack, rd0_ack, wr1_ack, wr0_ack}), 64'd0);
    check("rst_valid", 64'({rd1_valid, rd0_valid}), 64'd0);
    check("rst_wr_en", 64'(ctl_wr_en), 64'd0);
    check("rst_rd_addr", 64'(ctl_rd_addr), 64'd0);
    check("rst_wr_addr", 64'(ctl_wr_addr), 64'd0);
    check("rst_wr_data", 64'(ctl_wr_data), 64'd0);
    check("rst_rd_data", 64'({rd1_data, rd0_data}), 64'd0);
    rst_n = 1'b1;

    // Idle: 8 cycles, no activity
    repeat (2) run_slot();

    // wr0 writes 0x00010, then rd1 reads it back
    w_pend[0] = 1'b1; w_addr[0] = 20'h00010; w_data[0] = 32'hDEADBEEF;
    run_slot();
    r_pend[1] = 1'b1; r_addr[1] = 20'h00010;
    repeat (3) run_slot();
    check("rd1_readback", 64'(rd1_data), 64'h0000_0000_DEAD_BEEF);

    // Both readers continuously: rd0 every slot until it drops
    r_pend[0] = 1'b1; r_sticky[0] = 1'b1; r_addr[0] = 20'h00003;
    r_pend[1] = 1'b1; r_sticky[1] = 1'b1; r_addr[1] = 20'h00004;
    repeat (4) run_slot();
    r_sticky[0] = 1'b0;
    repeat (3) run_slot();
    r_sticky[1] = 1'b0;
    repeat (3) run_slot();

    // Both writers continuously
    w_pend[0] = 1'b1; w_sticky[0] = 1'b1; w_addr[0] = 20'h00008; w_data[0] = 32'h1111_0000;
    w_pend[1] = 1'b1; w_sticky[1] = 1'b1; w_addr[1] = 20'h00009; w_data[1] = 32'h2222_0000;
    repeat (4) run_slot();
    w_sticky[0] = 1'b0; w_sticky[1] = 1'b0;
    repeat (3) run_slot();

    // Same-address read and write in one slot, then a read in the next slot
    r_pend[0] = 1'b1; r_addr[0] = 20'h00020;
    run_slot();
    w_pend[0] = 1'b1; w_addr[0] = 20'h00020; w_data[0] = 32'h12345678;
    r_pend[1] = 1'b1; r_addr[1] = 20'h00020;
    repeat (2) run_slot();
    check("same_slot_old", 64'(rd0_data), 64'h0000_0000_A5A5_0020);
    check("next_slot_new", 64'(rd1_data), 64'h0000_0000_1234_5678);
    repeat (2) run_slot();

    // Randomized traffic
    rand_mode = 1'b1;
    repeat (150) run_slot();
    rand_mode = 1'b0;
    repeat (4) run_slot();

    // Reset during p2 with a read and a write in flight
    r_pend[0] = 1'b1; r_addr[0] = 20'h00007;
    run_slot();
    check("rst_pre_ack", 64'(rd0_ack), 64'd1);
    r_pend[0] = 1'b0;
    w_pend[0] = 1'b1; w_addr[0] = 20'h00007; w_data[0] = 32'hCAFEF00D;
    drive();
    @(negedge clk_100m);
    @(negedge clk_100m);
    check("rst_pre_wr_en", 64'(ctl_wr_en), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_wr_en", 64'(ctl_wr_en), 64'd0);
    check("rst_mid_phase", 64'(phase), 64'd0);
    check("rst_mid_acks", 64'({rd1_ack, rd0_ack, wr1_ack, wr0_ack}), 64'd0);
    model_reset();
    drive();
    repeat (3) begin
      @(negedge clk_100m);
      check("rst_hold_valid", 64'({rd1_valid, rd0_valid}), 64'd0);
    end
    rst_n = 1'b1;
    repeat (3) run_slot();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
